// File: rtl/acc_freq_meter_pkg.sv
// rtl/acc_freq_meter_pkg.sv - shared FSM encodings and saturating increment for acc_freq_meter
package acc_freq_meter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gate_state_e;

  typedef enum logic {
    P_WAIT = 1'b0,
    P_MEAS = 1'b1
  } per_state_e;

  // Callers zero-extend their counter to 32 bits and cast the result back down.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - rising-edge detector; previous value resets high so a level
// already asserted at reset release is not reported as an edge
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb prev_d = din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= prev_d;
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/acc_freq_meter.sv
// rtl/acc_freq_meter.sv - counts ACCM carry-out edges per gate window and
// measures the MSB period in clocks
module acc_freq_meter
  import acc_freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 65536,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             CO,
  input  logic             Mx,
  output logic [CNT_W-1:0] FREQ,
  output logic             OVF,
  output logic             RDY,
  output logic [CNT_W-1:0] PER,
  output logic             PER_OVF,
  output logic             PER_RDY
);

  localparam int               GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(32'(v), 32'(CNT_MAX)));
  endfunction

  logic co_rise;
  logic mx_rise;

  edge_det u_co_edge (.clk(clk), .rst_n(rst_n), .din(CO), .rise(co_rise));
  edge_det u_mx_edge (.clk(clk), .rst_n(rst_n), .din(Mx), .rise(mx_rise));

  gate_state_e      gate_state_q, gate_state_d;
  logic [GATE_W-1:0] gate_cnt_q,  gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q,  edge_cnt_d;
  logic              sat_q,       sat_d;
  logic [CNT_W-1:0]  freq_q,      freq_d;
  logic              ovf_q,       ovf_d;
  logic              rdy_q,       rdy_d;

  per_state_e        per_state_q, per_state_d;
  logic [CNT_W-1:0]  per_cnt_q,   per_cnt_d;
  logic              psat_q,      psat_d;
  logic [CNT_W-1:0]  per_q,       per_d;
  logic              per_ovf_q,   per_ovf_d;
  logic              per_rdy_q,   per_rdy_d;

  logic [CNT_W-1:0]  edge_cnt_nxt;
  logic              sat_nxt;

  // The last gate cycle's own edge (and any saturation it causes) belongs to the closing window.
  always_comb begin
    gate_state_d = gate_state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    sat_d        = sat_q;
    freq_d       = freq_q;
    ovf_d        = ovf_q;
    rdy_d        = 1'b0;
    edge_cnt_nxt = co_rise ? cnt_inc(edge_cnt_q) : edge_cnt_q;
    sat_nxt      = sat_q | (co_rise & (edge_cnt_q == CNT_MAX));

    case (gate_state_q)
      IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        if (en) gate_state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          gate_state_d = IDLE;
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          sat_d        = 1'b0;
        end else if (gate_cnt_q == GATE_LAST) begin
          freq_d     = edge_cnt_nxt;
          ovf_d      = sat_nxt;
          rdy_d      = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          edge_cnt_d = edge_cnt_nxt;
          sat_d      = sat_nxt;
        end
      end
      default: gate_state_d = IDLE;
    endcase
  end

  always_comb begin
    per_state_d = per_state_q;
    per_cnt_d   = per_cnt_q;
    psat_d      = psat_q;
    per_d       = per_q;
    per_ovf_d   = per_ovf_q;
    per_rdy_d   = 1'b0;

    case (per_state_q)
      P_WAIT: begin
        per_cnt_d = '0;
        psat_d    = 1'b0;
        if (en && mx_rise) begin
          per_state_d = P_MEAS;
          per_cnt_d   = CNT_W'(1);
        end
      end
      P_MEAS: begin
        if (!en) begin
          per_state_d = P_WAIT;
          per_cnt_d   = '0;
          psat_d      = 1'b0;
        end else if (mx_rise) begin
          per_d     = per_cnt_q;
          per_ovf_d = psat_q;
          per_rdy_d = 1'b1;
          per_cnt_d = CNT_W'(1);
          psat_d    = 1'b0;
        end else begin
          per_cnt_d = cnt_inc(per_cnt_q);
          psat_d    = psat_q | (per_cnt_q == CNT_MAX);
        end
      end
      default: per_state_d = P_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_state_q <= IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      sat_q        <= 1'b0;
      freq_q       <= '0;
      ovf_q        <= 1'b0;
      rdy_q        <= 1'b0;
      per_state_q  <= P_WAIT;
      per_cnt_q    <= '0;
      psat_q       <= 1'b0;
      per_q        <= '0;
      per_ovf_q    <= 1'b0;
      per_rdy_q    <= 1'b0;
    end else begin
      gate_state_q <= gate_state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      sat_q        <= sat_d;
      freq_q       <= freq_d;
      ovf_q        <= ovf_d;
      rdy_q        <= rdy_d;
      per_state_q  <= per_state_d;
      per_cnt_q    <= per_cnt_d;
      psat_q       <= psat_d;
      per_q        <= per_d;
      per_ovf_q    <= per_ovf_d;
      per_rdy_q    <= per_rdy_d;
    end
  end

  assign FREQ    = freq_q;
  assign OVF     = ovf_q;
  assign RDY     = rdy_q;
  assign PER     = per_q;
  assign PER_OVF = per_ovf_q;
  assign PER_RDY = per_rdy_q;

endmodule

// File: doc/acc_freq_meter.md
# acc_freq_meter

Measurement stage directly downstream of the ACCM phase accumulator. It consumes the accumulator's carry-out (CO) and MSB (Mx) and reports two figures. The first is the number of CO rising edges per fixed gate window, which is the output frequency in carries per window. The second is the Mx period in clocks between consecutive Mx rising edges. Results drive the display/readout stage; everything runs in the single system clock domain.

## Interface
- GATE_CYCLES, 65536: gate window length in clocks, ≥2.
- CNT_W, 16: width of FREQ and PER counters/outputs.
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  measurement enable, level.
- CO  in  1  ACCM carry-out.
- Mx  in  1  ACCM MSB.
- FREQ  out  CNT_W  CO edge count of last completed window.
- OVF  out  1  last completed window's edge count saturated.
- RDY  out  1  one-cycle strobe: FREQ/OVF updated.
- PER  out  CNT_W  clocks between last two Mx rising edges.
- PER_OVF  out  1  last period saturated.
- PER_RDY  out  1  one-cycle strobe: PER/PER_OVF updated.

## Operation
- Edge detect: co_d/mx_d hold the previous-cycle input. edge = in & ~in_d, evaluated in the current cycle.
  - co_d and mx_d reset to 1, so a level already high at reset release is not an edge.
- Gate FSM, states IDLE and RUN:
  - IDLE: gate counter and edge counter held at 0. IDLE→RUN when en=1.
  - RUN: gate counter increments every cycle. Edge counter increments on a CO edge and saturates at 2^CNT_W−1; the saturation event sets a window-local sat flag.
  - Last gate cycle (gate counter = GATE_CYCLES−1):
    - FREQ ← edge count plus this cycle's edge, saturating.
    - OVF ← sat, including saturation caused in this cycle.
    - RDY pulses.
    - Counters and sat clear; the next window starts on the next cycle with no dead cycles.
  - RUN→IDLE when en=0. The partial window is discarded: no RDY, and FREQ/OVF hold.
- Period FSM, states P_WAIT and P_MEAS:
  - P_WAIT: period counter at 0. On an Mx edge, go to P_MEAS with counter=1.
  - P_MEAS: counter increments each cycle and saturates at 2^CNT_W−1, setting psat. On an Mx edge: PER ← counter, PER_OVF ← psat, PER_RDY pulses, counter ← 1, psat clears.
  - en=0 forces P_WAIT. No PER_RDY is issued and PER/PER_OVF hold.
- Reset (asynchronous, immediate): FREQ, OVF, RDY, PER, PER_OVF, PER_RDY = 0. States go to IDLE/P_WAIT, all counters 0, co_d = mx_d = 1.
- CO high for several cycles counts once. Simultaneous CO and Mx edges are handled independently.

## Timing
- Let t0 be the first clock edge sampling en=1.
- Window k covers cycles t0+kG … t0+kG+G−1.
- FREQ/OVF/RDY are registered at edge t0+(k+1)G, visible for one cycle with RDY.
- Edge in the last gate cycle → counted in the current window. Edge in the first cycle of the next window → counted in the next window.
- PER_RDY is registered at the clock edge that samples the terminating Mx edge.
- PER = number of clock edges from the starting Mx edge to the terminating one.
- All outputs are registers; there are no combinational input-to-output paths.

## Structure
- Shared package: FSM state encodings (IDLE/RUN, P_WAIT/P_MEAS) and a saturating-increment function.
- One sub-module, edge_det: a 1-bit previous-value register with reset-to-1 plus a rising-edge output. Instantiated twice, for CO and Mx.
- Gate and period logic live in the top module.

## Test plan
- Reset with CO=Mx=1 held, then release with en=1 → all outputs 0 and no edge counted. First RDY at t0+G with FREQ=0.
- G=16, five 1-cycle CO pulses in window 0 → RDY once at t0+16 with FREQ=5, OVF=0. A 3-cycle-wide CO pulse counts as 1.
- ACCM upstream with X=100, G=65536, 16-bit ACC from 0 → FREQ=100 every window. PER alternates 655/656; every PER_RDY shows PER∈{655,656}.
- CNT_W=4, G=64, CO toggling every 2 cycles (16 edges) → FREQ=15, OVF=1. Next window with 3 edges → FREQ=3, OVF=0.
- Boundary edges:
  - CO edge on gate cycle G−1 → in window k.
  - CO edge on the next cycle → in window k+1.
  - Mx edges 40000 cycles apart with CNT_W=8 → PER=255, PER_OVF=1.
- Control mid-operation:
  - en dropped mid-window → no RDY/PER_RDY and outputs hold. Re-enabling restarts the window and requires a new first Mx edge.
  - rst_n pulsed low mid-window → outputs 0 asynchronously, before the next clk edge.
